// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: receive side of one HDMI TMDS channel.
// Hunts for word alignment using runs of control tokens and bitslip requests,
// then decodes aligned 10-bit words into pixel data, DE and {C1,C0}.
//
// Optional TERC4 decode is compiled in when TMDS_DEC_TERC4_EN is defined;
// otherwise terc4 and terc4_valid stay 0.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   tmds_word    deserialized word, bit 0 is the first serial bit
//   bitslip      one-cycle request to shift deserializer alignment by one bit
//   aligned      lock status
//   slip_count   bitslips issued since reset, modulo 10
//   de, c, data  decoded data enable, {C1,C0}, pixel byte (2 clk latency)
//   terc4        TERC4 nibble, terc4_valid flags a TERC4 match (2 clk latency)
module tmds_channel_decoder #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SLIP_WAIT      = 16,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_count,
  output logic       de,
  output logic [1:0] c,
  output logic [7:0] data,
  output logic [3:0] terc4,
  output logic       terc4_valid
);

  localparam int unsigned RUN_W  = (CTRL_RUN > 1)       ? $clog2(CTRL_RUN)       : 1;
  localparam int unsigned TCNT_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int unsigned WCNT_W = (SLIP_WAIT > 1)      ? $clog2(SLIP_WAIT)      : 1;
  localparam int unsigned LCNT_W = (LOSS_TIMEOUT > 1)   ? $clog2(LOSS_TIMEOUT)   : 1;

  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(CTRL_RUN - 1);
  localparam logic [TCNT_W-1:0] T_LAST   = TCNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] W_LAST   = WCNT_W'(SLIP_WAIT - 1);
  localparam logic [LCNT_W-1:0] L_LAST   = LCNT_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [9:0]          w;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic [LCNT_W-1:0]   lcnt, lcnt_nxt;
  logic [3:0]          slip_nxt;
  logic                bitslip_nxt, aligned_nxt, de_nxt, t4v_nxt;
  logic [1:0]          c_nxt;
  logic [7:0]          data_nxt;
  logic [3:0]          t4_nxt;

  logic                is_tok;
  logic [1:0]          tok_c;
  logic [7:0]          q, dec;
  logic                t4_hit;
  logic [3:0]          t4_idx;

  // Control token detect on the registered word
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (w)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  // TMDS data decode: undo optional inversion, then XOR/XNOR chain
  always_comb begin
    q      = w[9] ? ~w[7:0] : w[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

`ifdef TMDS_DEC_TERC4_EN
  // TERC4 codeword lookup (HDMI 1.4 data island encoding)
  always_comb begin
    t4_hit = 1'b1;
    t4_idx = 4'd0;
    case (w)
      10'b1010011100: t4_idx = 4'd0;
      10'b1001100011: t4_idx = 4'd1;
      10'b1011100100: t4_idx = 4'd2;
      10'b1011100010: t4_idx = 4'd3;
      10'b0101110001: t4_idx = 4'd4;
      10'b0100011110: t4_idx = 4'd5;
      10'b0110001110: t4_idx = 4'd6;
      10'b0100111100: t4_idx = 4'd7;
      10'b1011001100: t4_idx = 4'd8;
      10'b0100111001: t4_idx = 4'd9;
      10'b0110011100: t4_idx = 4'd10;
      10'b1011000110: t4_idx = 4'd11;
      10'b1010001110: t4_idx = 4'd12;
      10'b1001110001: t4_idx = 4'd13;
      10'b0101100011: t4_idx = 4'd14;
      10'b1011000011: t4_idx = 4'd15;
      default:        t4_hit = 1'b0;
    endcase
  end
`else
  assign t4_hit = 1'b0;
  assign t4_idx = 4'd0;
`endif

  // Alignment FSM next-state and registered-output computation
  always_comb begin
    state_nxt   = state;
    run_nxt     = run_cnt;
    tcnt_nxt    = tcnt;
    wcnt_nxt    = wcnt;
    lcnt_nxt    = lcnt;
    slip_nxt    = slip_count;
    bitslip_nxt = 1'b0;

    case (state)
      ST_SEARCH: begin
        // Lock wins over timeout when both land on the same cycle
        if (is_tok && (run_cnt == RUN_LAST)) begin
          state_nxt = ST_LOCKED;
          run_nxt   = '0;
          tcnt_nxt  = '0;
          lcnt_nxt  = '0;
        end else if (tcnt == T_LAST) begin
          state_nxt = ST_SLIP;
          run_nxt   = '0;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
          run_nxt  = is_tok ? (run_cnt + RUN_W'(1)) : '0;
        end
      end
      ST_SLIP: begin
        bitslip_nxt = 1'b1;
        slip_nxt    = (slip_count == 4'd9) ? 4'd0 : (slip_count + 4'd1);
        wcnt_nxt    = '0;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        // Deserializer is settling; words are ignored here
        if (wcnt == W_LAST) begin
          state_nxt = ST_SEARCH;
          wcnt_nxt  = '0;
          tcnt_nxt  = '0;
          run_nxt   = '0;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          lcnt_nxt = '0;
        end else if (lcnt == L_LAST) begin
          // Lock lost: resume searching at the current alignment, no slip
          state_nxt = ST_SEARCH;
          lcnt_nxt  = '0;
          tcnt_nxt  = '0;
          run_nxt   = '0;
        end else begin
          lcnt_nxt = lcnt + LCNT_W'(1);
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase

    // Decoded outputs follow the lock status they are registered alongside
    aligned_nxt = (state_nxt == ST_LOCKED);
    de_nxt      = 1'b0;
    data_nxt    = '0;
    c_nxt       = aligned_nxt ? c : 2'b00;
    if (aligned_nxt) begin
      if (is_tok) begin
        c_nxt = tok_c;
      end else begin
        de_nxt   = 1'b1;
        data_nxt = dec;
      end
    end
    t4v_nxt = aligned_nxt & t4_hit;
    t4_nxt  = t4v_nxt ? t4_idx : 4'd0;
  end

  // Stage 1 word register, FSM state, stage 2 outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      w           <= '0;
      state       <= ST_SEARCH;
      run_cnt     <= '0;
      tcnt        <= '0;
      wcnt        <= '0;
      lcnt        <= '0;
      slip_count  <= '0;
      bitslip     <= 1'b0;
      aligned     <= 1'b0;
      de          <= 1'b0;
      c           <= '0;
      data        <= '0;
      terc4       <= '0;
      terc4_valid <= 1'b0;
    end else begin
      w           <= tmds_word;
      state       <= state_nxt;
      run_cnt     <= run_nxt;
      tcnt        <= tcnt_nxt;
      wcnt        <= wcnt_nxt;
      lcnt        <= lcnt_nxt;
      slip_count  <= slip_nxt;
      bitslip     <= bitslip_nxt;
      aligned     <= aligned_nxt;
      de          <= de_nxt;
      c           <= c_nxt;
      data        <= data_nxt;
      terc4       <= t4_nxt;
      terc4_valid <= t4v_nxt;
    end
  end

endmodule
